// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL single-beat SRAM manager with a one-entry registered D response.
// Optional per-word poison tracking: define TL_SRAM_POISON_EN.
module tl_ul_sram_responder #(
  parameter logic [30:0] BASE_ADDR = 31'h1000_0000,
  parameter int unsigned DEPTH     = 64,
  parameter logic        SINK_ID   = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_in_a_valid,
  output logic        auto_in_a_ready,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic [7:0]  auto_in_a_bits_source,
  input  logic [30:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  output logic        auto_in_d_valid,
  input  logic        auto_in_d_ready,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [2:0]  auto_in_d_bits_size,
  output logic [7:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(DEPTH * 8);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_a_ready;
  logic        w_a_fire;
  logic        w_d_fire;
  logic [30:0] w_off;
  logic        w_in_range;
  logic        w_ok;
  logic [AW-1:0] w_idx;
  logic [63:0] w_rd;
  logic        w_prd;
  logic        w_is_put;
  logic        w_is_get;
  logic        w_is_atom;
  logic        w_is_hint;
  logic        w_we;
  logic [2:0]  w_op;
  logic        w_den;
  logic [63:0] w_dat;
  logic        w_cor;

  logic [63:0] r_mem [DEPTH];
  logic [2:0]  r_op;
  logic [2:0]  r_size;
  logic [7:0]  r_src;
  logic        r_den;
  logic [63:0] r_dat;
  logic        r_cor;

  assign w_off      = auto_in_a_bits_address - BASE_ADDR;
  assign w_in_range = {1'b0, w_off} < LIMIT;
  assign w_idx      = w_off[AW+2:3];
  assign w_ok       = w_in_range & (auto_in_a_bits_size <= 3'd3);
  assign w_rd       = r_mem[w_idx];

  assign w_is_put  = auto_in_a_bits_opcode[2:1] == 2'b00;
  assign w_is_atom = auto_in_a_bits_opcode[2:1] == 2'b01;
  assign w_is_get  = auto_in_a_bits_opcode == 3'd4;
  assign w_is_hint = auto_in_a_bits_opcode == 3'd5;

  always_comb begin
    w_a_ready   = (r_state == S_EMPTY) | auto_in_d_ready;
    w_a_fire    = auto_in_a_valid & w_a_ready;
    w_d_fire    = (r_state == S_FULL) & auto_in_d_ready;
    w_state_nxt = r_state;
    if (w_a_fire)
      w_state_nxt = S_FULL;
    else if (w_d_fire)
      w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_op  = 3'd0;
    w_den = 1'b1;
    w_dat = '0;
    w_cor = 1'b0;
    w_we  = 1'b0;
    unique case (1'b1)
      w_is_put: begin
        w_den = ~w_ok;
        w_we  = w_ok;
      end
      w_is_get: begin
        w_op = 3'd1;
        if (w_ok) begin
          w_den = 1'b0;
          w_dat = w_rd;
          w_cor = w_prd;
        end else begin
          w_cor = 1'b1;
        end
      end
      w_is_atom: begin
        w_op  = 3'd1;
        w_cor = 1'b1;
      end
      w_is_hint: begin
        w_op  = 3'd2;
        w_den = ~w_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_a_fire && w_we) begin
      for (int b = 0; b < 8; b++) begin
        if (auto_in_a_bits_mask[b])
          r_mem[w_idx][8*b +: 8] <= auto_in_a_bits_data[8*b +: 8];
      end
    end
  end

`ifdef TL_SRAM_POISON_EN
  logic [DEPTH-1:0] r_poison;
  logic             w_unused;

  assign w_prd    = r_poison[w_idx];
  assign w_unused = ^auto_in_a_bits_param;

  // PutFull replaces the poison state, PutPartial can only add to it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_poison <= '0;
    end else if (w_a_fire && w_we) begin
      if (auto_in_a_bits_opcode == 3'd0)
        r_poison[w_idx] <= auto_in_a_bits_corrupt;
      else
        r_poison[w_idx] <= r_poison[w_idx] | auto_in_a_bits_corrupt;
    end
  end
`else
  logic w_unused;

  assign w_prd    = 1'b0;
  assign w_unused = ^{auto_in_a_bits_param, auto_in_a_bits_corrupt};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op   <= '0;
      r_size <= '0;
      r_src  <= '0;
      r_den  <= 1'b0;
      r_dat  <= '0;
      r_cor  <= 1'b0;
    end else if (w_a_fire) begin
      r_op   <= w_op;
      r_size <= auto_in_a_bits_size;
      r_src  <= auto_in_a_bits_source;
      r_den  <= w_den;
      r_dat  <= w_dat;
      r_cor  <= w_cor;
    end
  end

  assign auto_in_a_ready        = w_a_ready;
  assign auto_in_d_valid        = r_state == S_FULL;
  assign auto_in_d_bits_opcode  = r_op;
  assign auto_in_d_bits_param   = 2'd0;
  assign auto_in_d_bits_size    = r_size;
  assign auto_in_d_bits_source  = r_src;
  assign auto_in_d_bits_sink    = SINK_ID;
  assign auto_in_d_bits_denied  = r_den;
  assign auto_in_d_bits_data    = r_dat;
  assign auto_in_d_bits_corrupt = r_cor;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Scoreboard bench for tl_ul_sram_responder.
// Poison expectations follow TL_SRAM_POISON_EN.
module tb_tl_ul_sram_responder;

  localparam logic [30:0] BASE = 31'h1000_0000;
  localparam int unsigned DEPTH = 64;

  logic        clock;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [7:0]  a_source;
  logic [30:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [7:0]  d_source;
  logic        d_sink;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;

  tl_ul_sram_responder dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_bits_opcode  (a_opcode),
    .auto_in_a_bits_param   (a_param),
    .auto_in_a_bits_size    (a_size),
    .auto_in_a_bits_source  (a_source),
    .auto_in_a_bits_address (a_address),
    .auto_in_a_bits_mask    (a_mask),
    .auto_in_a_bits_data    (a_data),
    .auto_in_a_bits_corrupt (a_corrupt),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_bits_opcode  (d_opcode),
    .auto_in_d_bits_param   (d_param),
    .auto_in_d_bits_size    (d_size),
    .auto_in_d_bits_source  (d_source),
    .auto_in_d_bits_sink    (d_sink),
    .auto_in_d_bits_denied  (d_denied),
    .auto_in_d_bits_data    (d_data),
    .auto_in_d_bits_corrupt (d_corrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [7:0]  src;
    logic        den;
    logic [63:0] data;
    logic        cor;
  } rsp_t;

  rsp_t        sb[$];
  logic [63:0] m_mem [DEPTH];
  bit          m_poi [DEPTH];
  int          errors = 0;
  int          checks = 0;

  // Reference behaviour of one accepted A request
  task automatic calc(input logic [2:0] op, input logic [2:0] size,
                      input logic [7:0] src, input logic [30:0] addr,
                      input logic [7:0] mask, input logic [63:0] data,
                      input bit cor, output rsp_t r);
    logic [30:0] off;
    int          idx;
    bit          ok;
    off = addr - BASE;
    idx = int'(off[8:3]);
    ok  = (off < 31'(DEPTH * 8)) && (size <= 3'd3);
    r.size = size; r.src = src; r.data = '0;
    r.cor = 1'b0; r.den = 1'b1; r.op = 3'd0;
    case (op)
      3'd0, 3'd1: begin
        r.den = !ok;
        if (ok) begin
          for (int b = 0; b < 8; b++)
            if (mask[b]) m_mem[idx][8*b +: 8] = data[8*b +: 8];
          m_poi[idx] = (op == 3'd0) ? cor : (m_poi[idx] | cor);
        end
      end
      3'd4: begin
        r.op = 3'd1;
        if (ok) begin
          r.den  = 1'b0;
          r.data = m_mem[idx];
`ifdef TL_SRAM_POISON_EN
          r.cor = m_poi[idx];
`endif
        end else begin
          r.cor = 1'b1;
        end
      end
      3'd2, 3'd3: begin r.op = 3'd1; r.cor = 1'b1; end
      3'd5: begin r.op = 3'd2; r.den = !ok; end
      default: ;
    endcase
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] size,
                      input logic [7:0] src, input logic [30:0] addr,
                      input logic [7:0] mask, input logic [63:0] data,
                      input bit cor);
    rsp_t r;
    bit   done;
    done = 0;
    a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src;
    a_address = addr; a_mask = mask; a_data = data; a_corrupt = cor;
    a_param = 3'd0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (a_ready) begin
        calc(op, size, src, addr, mask, data, cor, r);
        sb.push_back(r);
        done = 1;
      end
      @(posedge clock); #1;
    end
    a_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout op=%0d addr=%h never accepted", op, addr);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clock);
    @(posedge clock); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required=0", name, sb.size());
    end
  endtask

  always @(negedge clock) begin
    if (reset && d_valid && d_ready) begin
      rsp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected op=%0d src=%0d data=%h",
                 d_opcode, d_source, d_data);
      end else begin
        e = sb.pop_front();
        if ({d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt}
            !== {e.op, 2'd0, e.size, e.src, 1'b0, e.den, e.data, e.cor}) begin
          errors++;
          $display("FAIL rsp op=%0d size=%0d src=%0d den=%0d data=%h cor=%0d required op=%0d size=%0d src=%0d den=%0d data=%h cor=%0d",
                   d_opcode, d_size, d_source, d_denied, d_data, d_corrupt,
                   e.op, e.size, e.src, e.den, e.data, e.cor);
        end
      end
    end
  end

  task automatic test_reset;
    #1;
    checks++;
    if ({d_valid, d_opcode, d_size, d_source, d_denied, d_data, d_corrupt} !== '0) begin
      errors++;
      $display("FAIL reset_d_bits valid=%0d data=%h required all 0", d_valid, d_data);
    end
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    checks++;
    if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release a_ready=%0d d_valid=%0d required 1/0", a_ready, d_valid);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_put_get;
    send(3'd0, 3'd3, 8'd5, BASE + 31'd8, 8'hFF, 64'h1122334455667788, 1'b0);
    checks++;
    if (d_valid !== 1'b1 || d_opcode !== 3'd0 || d_source !== 8'd5 || d_denied !== 1'b0) begin
      errors++;
      $display("FAIL put_ack valid=%0d op=%0d src=%0d den=%0d required 1/0/5/0",
               d_valid, d_opcode, d_source, d_denied);
    end
    send(3'd4, 3'd3, 8'd6, BASE + 31'd8, 8'hFF, 64'd0, 1'b0);
    checks++;
    if (d_valid !== 1'b1 || d_opcode !== 3'd1 || d_data !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL get_latency valid=%0d op=%0d data=%h required 1/1/1122334455667788",
               d_valid, d_opcode, d_data);
    end
    wait_drain("put_get");
  endtask

  task automatic test_partial;
    send(3'd0, 3'd3, 8'd1, BASE + 31'd24, 8'hFF, {8{8'h55}}, 1'b0);
    send(3'd1, 3'd3, 8'd2, BASE + 31'd24, 8'h0F, {8{8'hAA}}, 1'b0);
    send(3'd4, 3'd3, 8'd3, BASE + 31'd24, 8'hFF, 64'd0, 1'b0);
    checks++;
    if (d_data !== 64'h55555555AAAAAAAA) begin
      errors++;
      $display("FAIL partial_data data=%h required 55555555aaaaaaaa", d_data);
    end
    wait_drain("partial");
  endtask

  task automatic test_back_to_back;
    logic [79:0] snap;
    d_ready = 1'b0;
    send(3'd4, 3'd3, 8'd10, BASE + 31'd8, 8'hFF, 64'd0, 1'b0);
    snap = {d_opcode, d_size, d_source, d_denied, d_data, d_corrupt};
    fork
      send(3'd4, 3'd3, 8'd11, BASE + 31'd24, 8'hFF, 64'd0, 1'b0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clock);
          checks++;
          if (a_ready !== 1'b0 || d_valid !== 1'b1 ||
              {d_opcode, d_size, d_source, d_denied, d_data, d_corrupt} !== snap) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d a_ready=%0d d_valid=%0d data=%h required 0/1/%h",
                     i, a_ready, d_valid, d_data, snap[64:1]);
          end
        end
        @(posedge clock); #1;
        d_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (a_ready !== 1'b1 || a_valid !== 1'b1 || d_valid !== 1'b1) begin
          errors++;
          $display("FAIL same_cycle a_ready=%0d a_valid=%0d d_valid=%0d required 1/1/1",
                   a_ready, a_valid, d_valid);
        end
      end
    join
    checks++;
    if (d_valid !== 1'b1 || d_source !== 8'd11 || d_data !== 64'h55555555AAAAAAAA) begin
      errors++;
      $display("FAIL second_get valid=%0d src=%0d data=%h required 1/11/55555555aaaaaaaa",
               d_valid, d_source, d_data);
    end
    wait_drain("back_to_back");
  endtask

  task automatic test_denials;
    send(3'd4, 3'd3, 8'd20, BASE + 31'(DEPTH * 8), 8'hFF, 64'd0, 1'b0);
    checks++;
    if (d_denied !== 1'b1 || d_corrupt !== 1'b1 || d_data !== 64'd0) begin
      errors++;
      $display("FAIL get_oob den=%0d cor=%0d data=%h required 1/1/0", d_denied, d_corrupt, d_data);
    end
    send(3'd0, 3'd4, 8'd21, BASE + 31'd8, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b0);
    checks++;
    if (d_denied !== 1'b1 || d_opcode !== 3'd0) begin
      errors++;
      $display("FAIL put_size4 den=%0d op=%0d required 1/0", d_denied, d_opcode);
    end
    send(3'd4, 3'd3, 8'd22, BASE + 31'd8, 8'hFF, 64'd0, 1'b0);
    checks++;
    if (d_data !== 64'h1122334455667788 || d_denied !== 1'b0) begin
      errors++;
      $display("FAIL mem_unchanged data=%h den=%0d required 1122334455667788/0", d_data, d_denied);
    end
    send(3'd2, 3'd3, 8'd23, BASE + 31'd8, 8'hFF, 64'd1, 1'b0);
    checks++;
    if (d_opcode !== 3'd1 || d_denied !== 1'b1 || d_corrupt !== 1'b1) begin
      errors++;
      $display("FAIL atomic op=%0d den=%0d cor=%0d required 1/1/1", d_opcode, d_denied, d_corrupt);
    end
    send(3'd5, 3'd2, 8'd24, BASE + 31'd16, 8'hFF, 64'd0, 1'b0);
    send(3'd7, 3'd3, 8'd25, BASE + 31'd16, 8'hFF, 64'd0, 1'b0);
    send(3'd4, 3'd3, 8'd26, BASE - 31'd8, 8'hFF, 64'd0, 1'b0);
    send(3'd4, 3'd3, 8'd27, BASE + 31'(DEPTH * 8 - 8), 8'hFF, 64'd0, 1'b0);
    send(3'd4, 3'd3, 8'd28, BASE + 31'd8, 8'hFF, 64'd0, 1'b0);
    wait_drain("denials");
  endtask

  task automatic test_poison;
    send(3'd0, 3'd3, 8'd30, BASE + 31'd32, 8'hFF, 64'h0123456789ABCDEF, 1'b1);
    send(3'd4, 3'd3, 8'd31, BASE + 31'd32, 8'hFF, 64'd0, 1'b0);
    checks++;
`ifdef TL_SRAM_POISON_EN
    if (d_corrupt !== 1'b1) begin
`else
    if (d_corrupt !== 1'b0) begin
`endif
      errors++;
      $display("FAIL poison_set cor=%0d", d_corrupt);
    end
    send(3'd0, 3'd3, 8'd32, BASE + 31'd32, 8'hFF, 64'h0123456789ABCDEF, 1'b0);
    send(3'd4, 3'd3, 8'd33, BASE + 31'd32, 8'hFF, 64'd0, 1'b0);
    checks++;
    if (d_corrupt !== 1'b0) begin
      errors++;
      $display("FAIL poison_clear cor=%0d required 0", d_corrupt);
    end
    send(3'd1, 3'd3, 8'd34, BASE + 31'd32, 8'h01, 64'd0, 1'b1);
    send(3'd4, 3'd3, 8'd35, BASE + 31'd32, 8'hFF, 64'd0, 1'b0);
    wait_drain("poison");
  endtask

  task automatic test_reset_mid;
    d_ready = 1'b0;
    send(3'd4, 3'd3, 8'd40, BASE + 31'd8, 8'hFF, 64'd0, 1'b0);
    #2 reset = 1'b0;
    #1;
    sb.delete();
    for (int i = 0; i < DEPTH; i++) m_poi[i] = 1'b0;
    checks++;
    if ({d_valid, d_opcode, d_size, d_source, d_denied, d_data, d_corrupt} !== '0) begin
      errors++;
      $display("FAIL reset_mid valid=%0d src=%0d data=%h required all 0", d_valid, d_source, d_data);
    end
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release a_ready=%0d d_valid=%0d required 1/0", a_ready, d_valid);
    end
    @(posedge clock); #1;
    d_ready = 1'b1;
    send(3'd4, 3'd3, 8'd41, BASE + 31'd24, 8'hFF, 64'd0, 1'b0);
    wait_drain("reset_mid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; d_ready = 1'b1; a_valid = 1'b0; a_opcode = '0; a_param = '0;
    a_size = '0; a_source = '0; a_address = '0; a_mask = '0; a_data = '0;
    a_corrupt = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_poi[i] = 1'b0;
    repeat (3) @(posedge clock);
    test_reset;
    test_put_get;
    test_partial;
    test_back_to_back;
    test_denials;
    test_poison;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_ul_sram_responder.md
Name: tl_ul_sram_responder

Overview:
TileLink-UL manager (responder) endpoint. It terminates the A channel that a TL buffer drives out of its auto_out side, and it drives the D channel back into that buffer. The backing store is a flop array of DEPTH 64-bit words. Only single-beat accesses are serviced. Each accepted request produces exactly one registered D response.

Parameters:
BASE_ADDR, 31'h1000_0000, byte address of word 0; must be 8-byte aligned.
DEPTH, 64, number of 64-bit words; power of two, range 2..1024.
SINK_ID, 1'b0, constant driven on d_sink.

Ports:
clock  in  1  sole clock.
reset  in  1  asynchronous, active-low reset (asserted when 0).
auto_in_a_valid  in  1  A request valid.
auto_in_a_ready  out  1  A accept.
auto_in_a_bits_opcode  in  3  A opcode.
auto_in_a_bits_param  in  3  A param; ignored.
auto_in_a_bits_size  in  3  log2 bytes.
auto_in_a_bits_source  in  8  requester ID.
auto_in_a_bits_address  in  31  byte address.
auto_in_a_bits_mask  in  8  byte lanes.
auto_in_a_bits_data  in  64  write data.
auto_in_a_bits_corrupt  in  1  write data poisoned.
auto_in_d_valid  out  1  D response valid.
auto_in_d_ready  in  1  D accept.
auto_in_d_bits_opcode  out  3  D opcode.
auto_in_d_bits_param  out  2  always 0.
auto_in_d_bits_size  out  3  echoes the A size.
auto_in_d_bits_source  out  8  echoes the A source.
auto_in_d_bits_sink  out  1  SINK_ID.
auto_in_d_bits_denied  out  1  request refused.
auto_in_d_bits_data  out  64  read data.
auto_in_d_bits_corrupt  out  1  read data invalid.

Behaviour:
- Reset (reset==0, async): d_valid=0; d_opcode, d_size, d_source, d_denied, d_data and d_corrupt all 0. Memory contents are not reset (undefined). A pending response is dropped. a_ready is 1 on the first cycle after deassertion.
- One-entry response register, states EMPTY and FULL. a_ready = (state==EMPTY) | d_ready, combinational.
- A fire = a_valid & a_ready. On A fire the response is latched and state goes to FULL, so d_valid is 1 on the next cycle (latency 1).
- D fire without A fire: state goes to EMPTY.
- Simultaneous A fire and D fire: state stays FULL with the new response, giving one response per cycle.
- D fields hold stable while d_valid & !d_ready.
- In range: off = address - BASE_ADDR, and off < DEPTH*8. Word index = off[.. :3].
- ok = in range & size<=3. Alignment is not checked; the mask defines the lanes.
- PutFullData (0) / PutPartialData (1):
  - If ok, write the mask-selected bytes at the A-fire edge.
  - Respond AccessAck (0), data 0, denied = !ok.
  - A denied write leaves memory unchanged.
- Get (4):
  - Respond AccessAckData (1), data = mem[index] sampled at A fire (full word, mask ignored).
  - If !ok: denied=1, corrupt=1, data=0.
- Read-after-write: a Get accepted the cycle after a Put to the same word returns the new data.
- ArithmeticData (2) / LogicalData (3): AccessAckData with denied=1, corrupt=1, data=0. No write.
- Intent (5): HintAck (2), denied = !ok.
- Opcodes 6/7: AccessAck with denied=1.
- a_valid held while a_ready=0: request is neither sampled nor written.

Optional Feature:
TL_SRAM_POISON_EN
- Defined:
  - One poison bit per word, reset to 0.
  - An ok PutFullData sets the bit to a_corrupt.
  - An ok PutPartialData ORs a_corrupt into the bit.
  - An ok Get returns corrupt = poison[index].
- Undefined: no poison storage, a_corrupt is ignored, and an ok Get returns corrupt=0.

Test Plan:
- Reset: hold reset=0 mid-response, then release -> d_valid=0 and a_ready=1 on the next cycle, all D bits 0.
- PutFull to BASE_ADDR+8, data 64'h1122334455667788, mask FF, source 5, then Get of the same address with d_ready=1 -> first response AccessAck, source 5, denied 0. Second response is AccessAckData with data 64'h1122334455667788 and is valid on the cycle after the Get is accepted.
- PutPartial, mask 8'h0F, data all 0xAA, over a word holding all 0x55, then Get -> data 64'h55555555AAAAAAAA.
- d_ready=0 for 3 cycles with 2 back-to-back Gets -> a_ready=0 while FULL. The second Get is accepted in the same cycle the first response fires. D fields stay stable throughout, with no loss or duplication.
- Denials:
  - Get at BASE_ADDR+DEPTH*8 -> denied=1, corrupt=1, data 0.
  - PutFull with size=4 -> denied=1 and memory unchanged.
  - Opcode 2 -> AccessAckData, denied=1.
- With TL_SRAM_POISON_EN: PutFull with corrupt=1, then Get -> corrupt=1. A clean PutFull followed by Get -> corrupt=0.
